// File: rtl/mips_ctrl_pkg.sv
// rtl/mips_ctrl_pkg.sv - shared encodings, control bundle type and bubble constant for the MIPS pipeline control
package mips_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_SLTI  = 6'b001010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10,
        ALUOP_IMM   = 2'b11
    } aluop_e;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

    typedef struct packed {
        logic       regwrite;
        logic       memtoreg;
        logic       memwrite;
        logic       branch;
        logic [2:0] aluctrl;
        logic       alusrc;
        logic       regdst;
    } ctrl_bundle_t;

    localparam ctrl_bundle_t BUBBLE = '0;

    function automatic logic [2:0] imm_aluctrl(input logic [5:0] opcode);
        case (opcode)
            OP_ANDI: imm_aluctrl = ALU_AND;
            OP_ORI:  imm_aluctrl = ALU_OR;
            default: imm_aluctrl = ALU_SLT;
        endcase
    endfunction

endpackage

// File: rtl/mips_hazard_unit.sv
// rtl/mips_hazard_unit.sv - load-use stall, branch/jump flush and EX-stage forwarding selects
module mips_hazard_unit
    import mips_ctrl_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] i_rs_d,
    input  logic [REG_AW-1:0] i_rt_d,
    input  logic [REG_AW-1:0] i_rs_e,
    input  logic [REG_AW-1:0] i_rt_e,
    input  logic              i_memtoreg_e,
    input  logic              i_branch_m,
    input  logic              i_zero_m,
    input  logic              i_regwrite_m,
    input  logic [REG_AW-1:0] i_writereg_m,
    input  logic              i_regwrite_w,
    input  logic [REG_AW-1:0] i_writereg_w,
    input  logic              i_jump_d,
    output logic              o_pcsrc_m,
    output logic              o_jump_d,
    output logic              o_stall_f,
    output logic              o_stall_d,
    output logic              o_flush_d,
    output logic              o_flush_e,
    output logic              o_flush_m,
    output logic [1:0]        o_fwd_a_e,
    output logic [1:0]        o_fwd_b_e
);

    logic w_lwstall;
    logic w_stall;

    function automatic logic [1:0] fwd_sel(
        input logic [REG_AW-1:0] src,
        input logic              rw_m,
        input logic [REG_AW-1:0] wr_m,
        input logic              rw_w,
        input logic [REG_AW-1:0] wr_w
    );
        if (rw_m && (wr_m != '0) && (wr_m == src))
            fwd_sel = FWD_M;
        else if (rw_w && (wr_w != '0) && (wr_w == src))
            fwd_sel = FWD_W;
        else
            fwd_sel = FWD_RF;
    endfunction

    assign o_pcsrc_m = i_branch_m & i_zero_m;
    assign w_lwstall = i_memtoreg_e & ((i_rt_e == i_rs_d) | (i_rt_e == i_rt_d));

    // A taken branch squashes the load-use pair, so it overrides the stall.
    assign w_stall   = w_lwstall & ~o_pcsrc_m;
    // A stalled jump is held in D and retried once the load has moved on.
    assign o_jump_d  = i_jump_d & ~w_stall;

    assign o_stall_f = w_stall;
    assign o_stall_d = w_stall;
    assign o_flush_d = o_pcsrc_m | o_jump_d;
    assign o_flush_e = o_pcsrc_m | w_stall;
    assign o_flush_m = o_pcsrc_m;

    assign o_fwd_a_e = fwd_sel(i_rs_e, i_regwrite_m, i_writereg_m, i_regwrite_w, i_writereg_w);
    assign o_fwd_b_e = fwd_sel(i_rt_e, i_regwrite_m, i_writereg_m, i_regwrite_w, i_writereg_w);

endmodule

// File: rtl/mips_pipe_ctrl.sv
// rtl/mips_pipe_ctrl.sv - decode and D/E/M/W control pipeline for the 5-stage MIPS core
module mips_pipe_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int REG_AW       = 5,
    parameter int ALUCTRL_W    = 3,
    parameter bit EN_IMM_LOGIC = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [5:0]           i_opcode_d,
    input  logic [5:0]           i_funct_d,
    input  logic [REG_AW-1:0]    i_rs_d,
    input  logic [REG_AW-1:0]    i_rt_d,
    input  logic [REG_AW-1:0]    i_rd_d,
    input  logic                 i_zero_m,
    output logic                 o_jump_d,
    output logic                 o_alusrc_e,
    output logic                 o_regdst_e,
    output logic [ALUCTRL_W-1:0] o_aluctrl_e,
    output logic                 o_memwrite_m,
    output logic                 o_pcsrc_m,
    output logic                 o_regwrite_w,
    output logic                 o_memtoreg_w,
    output logic [REG_AW-1:0]    o_writereg_w,
    output logic                 o_stall_f,
    output logic                 o_stall_d,
    output logic                 o_flush_d,
    output logic [1:0]           o_fwd_a_e,
    output logic [1:0]           o_fwd_b_e,
    output logic                 o_illegal_d
);

    ctrl_bundle_t      w_main_d;
    ctrl_bundle_t      w_ctrl_d;
    aluop_e            w_aluop_d;
    logic              w_uses_alu_d;
    logic              w_jump_raw_d;
    logic              w_bad_op_d;
    logic              w_bad_fn_d;
    logic [2:0]        w_aluctrl_d;
    logic              w_illegal_d;
    logic [REG_AW-1:0] w_writereg_e;
    logic              w_flush_e;
    logic              w_flush_m;

    ctrl_bundle_t      r_ctrl_e;
    logic [REG_AW-1:0] r_rs_e;
    logic [REG_AW-1:0] r_rt_e;
    logic [REG_AW-1:0] r_rd_e;
    ctrl_bundle_t      r_ctrl_m;
    logic [REG_AW-1:0] r_writereg_m;
    ctrl_bundle_t      r_ctrl_w;
    logic [REG_AW-1:0] r_writereg_w;

    always_comb begin
        w_main_d     = BUBBLE;
        w_aluop_d    = ALUOP_ADD;
        w_uses_alu_d = 1'b1;
        w_jump_raw_d = 1'b0;
        w_bad_op_d   = 1'b0;
        case (i_opcode_d)
            OP_RTYPE: begin
                w_main_d.regwrite = 1'b1;
                w_main_d.regdst   = 1'b1;
                w_aluop_d         = ALUOP_FUNCT;
            end
            OP_LW: begin
                w_main_d.regwrite = 1'b1;
                w_main_d.alusrc   = 1'b1;
                w_main_d.memtoreg = 1'b1;
            end
            OP_SW: begin
                w_main_d.alusrc   = 1'b1;
                w_main_d.memwrite = 1'b1;
            end
            OP_BEQ: begin
                w_main_d.branch   = 1'b1;
                w_aluop_d         = ALUOP_SUB;
            end
            OP_ADDI: begin
                w_main_d.regwrite = 1'b1;
                w_main_d.alusrc   = 1'b1;
            end
            OP_J: begin
                w_jump_raw_d = 1'b1;
                w_uses_alu_d = 1'b0;
            end
            OP_ANDI, OP_ORI, OP_SLTI: begin
                if (EN_IMM_LOGIC) begin
                    w_main_d.regwrite = 1'b1;
                    w_main_d.alusrc   = 1'b1;
                    w_aluop_d         = ALUOP_IMM;
                end else begin
                    w_bad_op_d = 1'b1;
                end
            end
            default: w_bad_op_d = 1'b1;
        endcase
    end

    always_comb begin
        w_aluctrl_d = ALU_ADD;
        w_bad_fn_d  = 1'b0;
        case (w_aluop_d)
            ALUOP_ADD: w_aluctrl_d = ALU_ADD;
            ALUOP_SUB: w_aluctrl_d = ALU_SUB;
            ALUOP_IMM: w_aluctrl_d = imm_aluctrl(i_opcode_d);
            default: begin
                case (i_funct_d)
                    FN_ADD:  w_aluctrl_d = ALU_ADD;
                    FN_SUB:  w_aluctrl_d = ALU_SUB;
                    FN_AND:  w_aluctrl_d = ALU_AND;
                    FN_OR:   w_aluctrl_d = ALU_OR;
                    FN_SLT:  w_aluctrl_d = ALU_SLT;
                    default: begin
                        w_aluctrl_d = ALU_AND;
                        w_bad_fn_d  = 1'b1;
                    end
                endcase
            end
        endcase
    end

    // Illegal instructions travel as bubbles, register fields included, so they never forward.
    assign w_illegal_d = w_bad_op_d | w_bad_fn_d;

    always_comb begin
        w_ctrl_d = w_main_d;
        w_ctrl_d.aluctrl = w_uses_alu_d ? w_aluctrl_d : 3'b000;
        if (w_illegal_d)
            w_ctrl_d = BUBBLE;
    end

    assign w_writereg_e = r_ctrl_e.regdst ? r_rd_e : r_rt_e;

    mips_hazard_unit #(
        .REG_AW(REG_AW)
    ) u_hazard (
        .i_rs_d       (i_rs_d),
        .i_rt_d       (i_rt_d),
        .i_rs_e       (r_rs_e),
        .i_rt_e       (r_rt_e),
        .i_memtoreg_e (r_ctrl_e.memtoreg),
        .i_branch_m   (r_ctrl_m.branch),
        .i_zero_m     (i_zero_m),
        .i_regwrite_m (r_ctrl_m.regwrite),
        .i_writereg_m (r_writereg_m),
        .i_regwrite_w (r_ctrl_w.regwrite),
        .i_writereg_w (r_writereg_w),
        .i_jump_d     (w_jump_raw_d & ~rst),
        .o_pcsrc_m    (o_pcsrc_m),
        .o_jump_d     (o_jump_d),
        .o_stall_f    (o_stall_f),
        .o_stall_d    (o_stall_d),
        .o_flush_d    (o_flush_d),
        .o_flush_e    (w_flush_e),
        .o_flush_m    (w_flush_m),
        .o_fwd_a_e    (o_fwd_a_e),
        .o_fwd_b_e    (o_fwd_b_e)
    );

    always_ff @(posedge clk) begin
        if (rst || w_flush_e || w_illegal_d) begin
            r_ctrl_e <= BUBBLE;
            r_rs_e   <= '0;
            r_rt_e   <= '0;
            r_rd_e   <= '0;
        end else begin
            r_ctrl_e <= w_ctrl_d;
            r_rs_e   <= i_rs_d;
            r_rt_e   <= i_rt_d;
            r_rd_e   <= i_rd_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || w_flush_m) begin
            r_ctrl_m     <= BUBBLE;
            r_writereg_m <= '0;
        end else begin
            r_ctrl_m     <= r_ctrl_e;
            r_writereg_m <= w_writereg_e;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ctrl_w     <= BUBBLE;
            r_writereg_w <= '0;
        end else begin
            r_ctrl_w     <= r_ctrl_m;
            r_writereg_w <= r_writereg_m;
        end
    end

    assign o_illegal_d  = w_illegal_d & ~rst;
    assign o_alusrc_e   = r_ctrl_e.alusrc;
    assign o_regdst_e   = r_ctrl_e.regdst;
    assign o_aluctrl_e  = ALUCTRL_W'(r_ctrl_e.aluctrl);
    assign o_memwrite_m = r_ctrl_m.memwrite;
    assign o_regwrite_w = r_ctrl_w.regwrite;
    assign o_memtoreg_w = r_ctrl_w.memtoreg;
    assign o_writereg_w = r_writereg_w;

endmodule
